// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequential ALU.
//   Opcode constants, FSM state encoding and bit positions inside the
//   5-bit flags word {err, V, S, Z, C}.
package alu_seq_pkg;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_MUL = 8'h03;
    localparam logic [7:0] OP_DIV = 8'h04;
    localparam logic [7:0] OP_SHL = 8'h0D;
    localparam logic [7:0] OP_SHR = 8'h0E;
    localparam logic [7:0] OP_CMP = 8'h0F;

    localparam int FLAG_C   = 0;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_S   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ERR = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter -- one-bit-per-cycle unsigned multiply / restoring divide.
//   clk, rst_n : clock, asynchronous active-low reset (clears partials)
//   start      : load operands and begin WIDTH iterations
//   mode       : 0 = multiply (a*b), 1 = divide (a/b)
//   a, b       : operands, captured on start
//   done       : high during the final iteration cycle
//   hi, lo     : value the partial registers take at the current edge;
//                at done this is {product_hi, product_lo} or {remainder, quotient}
module alu_seq_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             busy;
    logic             mode_q;
    logic [5:0]       count;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        // Multiply: add multiplicand into upper half when the lsb is set,
        // then shift the whole {carry, hi, lo} right by one.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd} : '0);
        // Divide: shift next dividend bit into the remainder, trial subtract.
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (mode_q) begin
            hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            hi = mul_sum[WIDTH:1];
            lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign done = busy && (count == 6'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mode_q <= 1'b0;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            mode_q <= mode;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= mode ? a : b;
            opnd   <= mode ? b : a;
        end else if (busy) begin
            hi_q  <= hi;
            lo_q  <= lo;
            count <= count + 6'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequential ALU with single-cycle ops and iterative MUL/DIV.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : request, taken only while ready=1
//   op            : 01 ADD, 02 SUB, 03 MUL, 04 DIV, 0D SHL, 0E SHR, 0F CMP
//   a, b          : operands (b is the shift amount for SHL/SHR)
//   ready         : idle, a start is accepted this cycle
//   done          : one-cycle pulse, result/result_hi/flags valid
//   result        : low result / quotient
//   result_hi     : MUL high half / DIV remainder, otherwise 0
//   flags         : {err, V, S, Z, C}
// Build option: define ALU_SEQ_MULDIV_EN to include MUL/DIV; without it
// opcodes 03/04 are treated as illegal and no iterative datapath exists.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);

    state_t state, state_next;

    logic                 accept;
    logic                 go_iter;
    logic                 keep;
    logic                 set_zs;
    logic [WIDTH-1:0]     zs_src;
    logic [WIDTH-1:0]     calc_res;
    logic [WIDTH-1:0]     calc_hi;
    logic [4:0]           calc_flags;
    logic [WIDTH:0]       add_w;
    logic [WIDTH:0]       sub_w;
    logic [2*WIDTH-1:0]   shl_w;
    logic [2*WIDTH-1:0]   shr_w;
    logic                 iter_done;

    assign ready  = (state == ST_IDLE);
    assign done   = (state == ST_DONE);
    assign accept = ready && start;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} - {1'b0, b};
    // Shifting inside a double-width window leaves the last bit shifted out
    // at position WIDTH (SHL) or WIDTH-1 (SHR); it is naturally 0 for b=0
    // and for b>WIDTH, and the result half is 0 for b>=WIDTH.
    assign shl_w = {{WIDTH{1'b0}}, a} << b;
    assign shr_w = {a, {WIDTH{1'b0}}} >> b;

    always_comb begin
        calc_res   = '0;
        calc_hi    = '0;
        calc_flags = '0;
        keep       = 1'b0;
        go_iter    = 1'b0;
        set_zs     = 1'b1;
        zs_src     = '0;
        case (op)
            OP_ADD: begin
                calc_res           = add_w[WIDTH-1:0];
                calc_flags[FLAG_C] = add_w[WIDTH];
                calc_flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) &&
                                     (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                calc_res           = sub_w[WIDTH-1:0];
                calc_flags[FLAG_C] = sub_w[WIDTH];
                calc_flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) &&
                                     (sub_w[WIDTH-1] != a[WIDTH-1]);
                keep               = (op == OP_CMP);
            end
            OP_SHL: begin
                calc_res           = shl_w[WIDTH-1:0];
                calc_flags[FLAG_C] = shl_w[WIDTH];
            end
            OP_SHR: begin
                calc_res           = shr_w[2*WIDTH-1:WIDTH];
                calc_flags[FLAG_C] = shr_w[WIDTH-1];
            end
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL: begin
                go_iter = 1'b1;
            end
            OP_DIV: begin
                if (b == '0) begin
                    calc_res             = '1;
                    calc_hi              = a;
                    calc_flags[FLAG_ERR] = 1'b1;
                end else begin
                    go_iter = 1'b1;
                end
            end
`endif
            default: begin
                set_zs               = 1'b0;
                calc_flags[FLAG_ERR] = 1'b1;
            end
        endcase
        if (set_zs) begin
            zs_src             = calc_res;
            calc_flags[FLAG_Z] = (zs_src == '0);
            calc_flags[FLAG_S] = zs_src[WIDTH-1];
        end
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && go_iter),
        .mode  (op == OP_DIV),
        .a     (a),
        .b     (b),
        .done  (iter_done),
        .hi    (iter_hi),
        .lo    (iter_lo)
    );
`else
    assign iter_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (go_iter) begin
                        state_next = (op == OP_DIV) ? ST_DIV : ST_MUL;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_done) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            result_hi <= '0;
            flags     <= '0;
        end else if (accept && !go_iter) begin
            if (!keep) begin
                result    <= calc_res;
                result_hi <= calc_hi;
            end
            flags <= calc_flags;
        end
`ifdef ALU_SEQ_MULDIV_EN
        else if (iter_done) begin
            result    <= iter_lo;
            result_hi <= iter_hi;
            if (state == ST_MUL) begin
                // Z covers the full double-width product.
                flags <= {1'b0, (iter_hi != '0), iter_hi[WIDTH-1],
                          ({iter_hi, iter_lo} == '0), (iter_hi != '0)};
            end else begin
                flags <= {1'b0, 1'b0, iter_lo[WIDTH-1], (iter_lo == '0), 1'b0};
            end
        end
`endif
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] op = 8'h00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic [4:0] flags;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation; returns after done is seen (or the budget runs out),
    // sampled 1 time unit after the edge. lat counts edges from acceptance.
    task automatic do_op(input logic [7:0] o, input logic [7:0] x, input logic [7:0] y,
                         input bit disturb, output int l);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 1;
        while (!done && l < 40) begin
            @(posedge clk); #1; l++;
            if (disturb && l == 3) begin
                a = 8'hFF; b = 8'hFF; op = 8'h01; start = 1'b1;
            end
            if (disturb && l == 4) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int l, input int exp_l,
                           input logic [7:0] r, input logic [7:0] rh, input logic [4:0] f);
        chk({tag, " lat"}, l, exp_l);
        chk({tag, " result"}, result, r);
        chk({tag, " result_hi"}, result_hi, rh);
        chk({tag, " flags"}, flags, f);
    endtask

    initial begin
        #12;
        chk("rst ready", ready, 1);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst result_hi", result_hi, 0);
        chk("rst flags", flags, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(8'h01, 8'hFF, 8'h01, 0, lat); chk_out("add ff+01", lat, 1, 8'h00, 8'h00, 5'h03);
        do_op(8'h01, 8'h7F, 8'h01, 0, lat); chk_out("add 7f+01", lat, 1, 8'h80, 8'h00, 5'h0C);
        do_op(8'h02, 8'h03, 8'h05, 0, lat); chk_out("sub 03-05", lat, 1, 8'hFE, 8'h00, 5'h05);
        do_op(8'h02, 8'h80, 8'h01, 0, lat); chk_out("sub 80-01", lat, 1, 8'h7F, 8'h00, 5'h08);
        do_op(8'h0F, 8'h05, 8'h03, 0, lat); chk_out("cmp 05,03", lat, 1, 8'h7F, 8'h00, 5'h00);
        do_op(8'h0F, 8'h03, 8'h05, 0, lat); chk_out("cmp 03,05", lat, 1, 8'h7F, 8'h00, 5'h05);
        do_op(8'h0D, 8'h01, 8'h02, 0, lat); chk_out("shl 01<<2", lat, 1, 8'h04, 8'h00, 5'h00);
        do_op(8'h0E, 8'h08, 8'h02, 0, lat); chk_out("shr 08>>2", lat, 1, 8'h02, 8'h00, 5'h00);
        do_op(8'h0D, 8'h81, 8'h01, 0, lat); chk_out("shl 81<<1", lat, 1, 8'h02, 8'h00, 5'h01);
        do_op(8'h0D, 8'h01, 8'h09, 0, lat); chk_out("shl 01<<9", lat, 1, 8'h00, 8'h00, 5'h02);
        do_op(8'h0D, 8'h01, 8'h08, 0, lat); chk_out("shl 01<<8", lat, 1, 8'h00, 8'h00, 5'h03);
        do_op(8'h0E, 8'h80, 8'h08, 0, lat); chk_out("shr 80>>8", lat, 1, 8'h00, 8'h00, 5'h03);
        do_op(8'h0E, 8'h81, 8'h00, 0, lat); chk_out("shr 81>>0", lat, 1, 8'h81, 8'h00, 5'h04);
        do_op(8'h07, 8'h12, 8'h34, 0, lat); chk_out("illegal 07", lat, 1, 8'h00, 8'h00, 5'h10);

        // Start held through the DONE cycle must not launch a second op.
        do_op(8'h01, 8'h10, 8'h20, 0, lat); chk_out("add 10+20", lat, 1, 8'h30, 8'h00, 5'h00);
        op = 8'h01; a = 8'h01; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done-cycle start ready", ready, 1);
        chk("done-cycle start done", done, 0);
        @(posedge clk); #1;
        chk("done-cycle start no pulse", done, 0);
        chk("done-cycle start result", result, 8'h30);

`ifdef ALU_SEQ_MULDIV_EN
        do_op(8'h03, 8'h0A, 8'h0F, 0, lat); chk_out("mul 0a*0f", lat, 9, 8'h96, 8'h00, 5'h00);
        do_op(8'h03, 8'h20, 8'h10, 0, lat); chk_out("mul 20*10", lat, 9, 8'h00, 8'h02, 5'h09);
        do_op(8'h03, 8'h00, 8'h37, 0, lat); chk_out("mul 00*37", lat, 9, 8'h00, 8'h00, 5'h02);
        do_op(8'h03, 8'hFF, 8'hFF, 0, lat); chk_out("mul ff*ff", lat, 9, 8'h01, 8'hFE, 5'h0D);
        do_op(8'h03, 8'h0A, 8'h0F, 1, lat); chk_out("mul disturbed", lat, 9, 8'h96, 8'h00, 5'h00);
        @(posedge clk); #1;
        chk("after mul disturbed done", done, 0);
        chk("after mul disturbed ready", ready, 1);
        do_op(8'h04, 8'h08, 8'h02, 0, lat); chk_out("div 08/02", lat, 9, 8'h04, 8'h00, 5'h00);
        do_op(8'h04, 8'h07, 8'h02, 0, lat); chk_out("div 07/02", lat, 9, 8'h03, 8'h01, 5'h00);
        do_op(8'h04, 8'hC8, 8'h03, 0, lat); chk_out("div c8/03", lat, 9, 8'h42, 8'h02, 5'h00);
        do_op(8'h04, 8'h08, 8'h00, 0, lat);
        chk("div0 lat", lat, 1);
        chk("div0 result", result, 8'hFF);
        chk("div0 result_hi", result_hi, 8'h08);
        chk("div0 err", flags[4], 1);
        chk("div0 C", flags[0], 0);

        // Abort a multiply part-way through with reset.
        op = 8'h03; a = 8'h0A; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("mul busy ready", ready, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort ready", ready, 1);
        chk("abort done", done, 0);
        chk("abort result", result, 0);
        chk("abort result_hi", result_hi, 0);
        chk("abort flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (done) seen++;
            end
            chk("abort no done", seen, 0);
        end
`else
        do_op(8'h03, 8'h0A, 8'h0F, 0, lat); chk_out("mul disabled", lat, 1, 8'h00, 8'h00, 5'h10);
        do_op(8'h04, 8'h08, 8'h02, 0, lat); chk_out("div disabled", lat, 1, 8'h00, 8'h00, 5'h10);
        do_op(8'h04, 8'h08, 8'h00, 0, lat); chk_out("div0 disabled", lat, 1, 8'h00, 8'h00, 5'h10);
        do_op(8'h02, 8'h80, 8'h01, 0, lat); chk_out("sub before rst", lat, 1, 8'h7F, 8'h00, 5'h08);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst ready", ready, 1);
        chk("async rst done", done, 0);
        chk("async rst result", result, 0);
        chk("async rst flags", flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        do_op(8'h01, 8'h01, 8'h02, 0, lat); chk_out("add after rst", lat, 1, 8'h03, 8'h00, 5'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
